alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 82 ++++++++
 rtl/alu_issue_alu.sv | 33 +++
 rtl/alu_issue.sv | 117 +++++++++++
 tb/tb_alu_issue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode constants, ALU control codes and the instruction decoder
//             shared by the ALU issue stage and its combinational ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      use_imm;
        br_kind_e  br;
        logic      illegal;
    } dec_t;

    function automatic dec_t alu_decode(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic       funct7_5
    );
        dec_t d;
        d.ctrl    = ALU_ADD;
        d.use_imm = 1'b0;
        d.br      = BR_NONE;
        d.illegal = 1'b0;
        case (opcode)
            c_op_reg: begin
                case (funct3)
                    3'b000:  d.ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  d.ctrl = ALU_AND;
                    3'b110:  d.ctrl = ALU_OR;
                    default: d.illegal = 1'b1;
                endcase
            end
            c_op_imm: begin
                d.use_imm = 1'b1;
                case (funct3)
                    3'b000:  d.ctrl = ALU_ADD;
                    3'b111:  d.ctrl = ALU_AND;
                    3'b110:  d.ctrl = ALU_OR;
                    default: d.illegal = 1'b1;
                endcase
            end
            // Loads and stores only need address generation.
            c_op_load, c_op_store: begin
                d.use_imm = 1'b1;
            end
            c_op_branch: begin
                d.ctrl = ALU_SUB;
                case (funct3)
                    3'b000:  d.br = BR_EQ;
                    3'b001:  d.br = BR_NE;
                    default: d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_alu
//  Purpose  : Combinational ALU (AND/OR/ADD/SUB) with zero detect.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_alu
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [3:0]          ctrl,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic [WORDSIZE-1:0] y,
    output logic                zero
);

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Two-stage ALU issue pipeline: S1 holds decoded control and
//             operands, S2 holds the result with valid/ready backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [WORDSIZE-1:0] rs1_data,
    input  logic [WORDSIZE-1:0] rs2_data,
    input  logic [WORDSIZE-1:0] imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] result,
    output logic                zero,
    output logic                br_taken,
    output logic                illegal
);

    dec_t                w_dec;
    logic                w_s2_adv;
    logic [WORDSIZE-1:0] w_alu_y;
    logic                w_alu_zero;

    logic                r_s1_valid;
    logic [3:0]          r_s1_ctrl;
    br_kind_e            r_s1_br;
    logic                r_s1_illegal;
    logic [WORDSIZE-1:0] r_s1_a;
    logic [WORDSIZE-1:0] r_s1_b;

    logic                r_out_valid;
    logic [WORDSIZE-1:0] r_result;
    logic                r_zero;
    logic                r_br_taken;
    logic                r_illegal;

    assign w_dec    = alu_decode(opcode, funct3, funct7_5);
    // S2 can take new contents when it is empty or being consumed.
    assign w_s2_adv = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_ctrl    <= ALU_ADD;
            r_s1_br      <= BR_NONE;
            r_s1_illegal <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ctrl    <= w_dec.ctrl;
                r_s1_br      <= w_dec.br;
                r_s1_illegal <= w_dec.illegal;
                r_s1_a       <= rs1_data;
                r_s1_b       <= w_dec.use_imm ? imm : rs2_data;
            end
        end
    end

    alu_issue_alu #(
        .WORDSIZE (WORDSIZE)
    ) u_alu (
        .ctrl (r_s1_ctrl),
        .a    (r_s1_a),
        .b    (r_s1_b),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_br_taken  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_illegal) begin
                    r_result   <= '0;
                    r_zero     <= 1'b1;
                    r_br_taken <= 1'b0;
                    r_illegal  <= 1'b1;
                end else begin
                    r_result   <= w_alu_y;
                    r_zero     <= w_alu_zero;
                    r_br_taken <= ((r_s1_br == BR_EQ) &  w_alu_zero) |
                                  ((r_s1_br == BR_NE) & ~w_alu_zero);
                    r_illegal  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign br_taken  = r_br_taken;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue: directed cases plus random
//             traffic against a scoreboard fed by an instruction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

    localparam int WORDSIZE = 64;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
    } op_t;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        br;
        logic        ill;
        int          cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [6:0]          opcode = '0;
    logic [2:0]          funct3 = '0;
    logic                funct7_5 = 1'b0;
    logic [WORDSIZE-1:0] rs1_data = '0;
    logic [WORDSIZE-1:0] rs2_data = '0;
    logic [WORDSIZE-1:0] imm = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WORDSIZE-1:0] result;
    logic                zero;
    logic                br_taken;
    logic                illegal;

    alu_issue #(.WORDSIZE(WORDSIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .br_taken (br_taken),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    bit          drv      = 1'b1;
    bit          chk_lat  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_res;
    logic [63:0] last_res;
    logic        last_z, last_br, last_ill;
    op_t         pend[$];
    exp_t        sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: what the instruction means, not how it is piped.
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [63:0] r;
        logic [63:0] bb;
        logic        ok;
        logic        br;
        ok = 1'b1; br = 1'b0; r = '0;
        bb = (o.op == 7'b0110011) ? o.b : o.imm;
        case (o.op)
            7'b0110011, 7'b0010011: begin
                if (o.f3 == 3'd0)      r = (o.op == 7'b0110011 && o.f7) ? o.a - bb : o.a + bb;
                else if (o.f3 == 3'd7) r = o.a & bb;
                else if (o.f3 == 3'd6) r = o.a | bb;
                else                   ok = 1'b0;
            end
            7'b0000011, 7'b0100011: r = o.a + o.imm;
            7'b1100011: begin
                r = o.a - o.b;
                if (o.f3 == 3'd0)      br = (o.a == o.b);
                else if (o.f3 == 3'd1) br = (o.a != o.b);
                else                   ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        e.res = ok ? r : 64'd0;
        e.z   = ok ? (r == 64'd0) : 1'b1;
        e.br  = ok & br;
        e.ill = ~ok;
        e.cyc = 0;
        return e;
    endfunction

    function automatic op_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
        op_t o;
        o.op = op; o.f3 = f3; o.f7 = f7; o.a = a; o.b = b; o.imm = im;
        return o;
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 15));
        return {$urandom, $urandom};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 6))
            0:       o.op = 7'b0110011;
            1:       o.op = 7'b0010011;
            2:       o.op = 7'b0000011;
            3:       o.op = 7'b0100011;
            4, 5:    o.op = 7'b1100011;
            default: o.op = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0:       o.f3 = 3'd0;
            1:       o.f3 = 3'd1;
            2:       o.f3 = 3'd6;
            3:       o.f3 = 3'd7;
            default: o.f3 = 3'($urandom);
        endcase
        o.f7  = 1'($urandom);
        o.a   = rnd64();
        o.b   = ($urandom_range(0, 2) == 0) ? o.a : rnd64();
        o.imm = rnd64();
        return o;
    endfunction

    // One clock: drive at the falling edge, observe handshakes 1ns later.
    task automatic step(input logic ordy);
        exp_t e;
        @(negedge clk);
        out_ready = ordy;
        if (drv && pend.size() > 0) begin
            in_valid = 1'b1;
            opcode   = pend[0].op;
            funct3   = pend[0].f3;
            funct7_5 = pend[0].f7;
            rs1_data = pend[0].a;
            rs2_data = pend[0].b;
            imm      = pend[0].imm;
        end else begin
            in_valid = 1'b0;
            opcode   = 7'($urandom);
            rs1_data = {$urandom, $urandom};
        end
        #1;
        if (prev_stall) check("hold_result", result, prev_res);
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result",   result,   e.res);
                check("zero",     zero,     e.z);
                check("br_taken", br_taken, e.br);
                check("illegal",  illegal,  e.ill);
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                last_res = result; last_z = zero; last_br = br_taken; last_ill = illegal;
            end
        end
        if (in_valid && in_ready) begin
            e     = model(pend[0]);
            e.cyc = cyc;
            sb.push_back(e);
            void'(pend.pop_front());
            n_acc++;
        end
        prev_stall = out_valid & ~out_ready;
        prev_res   = result;
        cyc++;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < bound) begin
            step(1'b1);
            n++;
        end
        check("drain_timeout", 64'(pend.size() + sb.size()), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_zero",      zero,      0);
        check("rst_br_taken",  br_taken,  0);
        check("rst_illegal",   illegal,   0);
        check("rst_in_ready",  in_ready,  1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_after_rst", in_ready, 1);

        // ADD with exact two-cycle latency
        chk_lat = 1'b1;
        pend.push_back(mk(7'b0110011, 3'd0, 1'b0, 64'd5, 64'd7, 64'd0));
        drain(10);
        check("add_result", last_res, 64'd12);
        check("add_zero",   last_z,   0);
        check("add_ill",    last_ill, 0);

        // BEQ / BNE on equal operands
        pend.push_back(mk(7'b1100011, 3'd0, 1'b0, 64'h1234, 64'h1234, 64'd0));
        drain(10);
        check("beq_result", last_res, 64'd0);
        check("beq_zero",   last_z,   1);
        check("beq_taken",  last_br,  1);
        pend.push_back(mk(7'b1100011, 3'd1, 1'b0, 64'h1234, 64'h1234, 64'd0));
        drain(10);
        check("bne_taken",  last_br,  0);

        // Wrap-around
        pend.push_back(mk(7'b0110011, 3'd0, 1'b1, 64'd0, 64'd1, 64'd0));
        drain(10);
        check("sub_wrap", last_res, {64{1'b1}});
        pend.push_back(mk(7'b0010011, 3'd0, 1'b1, {64{1'b1}}, 64'd9, 64'd1));
        drain(10);
        check("addi_wrap", last_res, 64'd0);
        check("addi_zero", last_z,   1);

        // Illegal followed by a normal ADD
        pend.push_back(mk(7'b0110111, 3'd0, 1'b0, 64'd3, 64'd4, 64'd5));
        pend.push_back(mk(7'b0110011, 3'd0, 1'b0, 64'd20, 64'd22, 64'd0));
        drain(10);
        check("after_illegal_add", last_res, 64'd42);
        check("after_illegal_ill", last_ill, 0);
        chk_lat = 1'b0;

        // Backpressure: 4 ORs against a stalled sink
        for (int i = 0; i < 4; i++)
            pend.push_back(mk(7'b0110011, 3'd6, 1'b0, 64'(i) << 8, 64'(i + 1), 64'd0));
        n_acc = 0;
        n_out = 0;
        repeat (5) step(1'b0);
        check("bp_accepted", 64'(n_acc), 64'd2);
        check("bp_in_ready", in_ready, 0);
        drain(20);
        check("bp_outputs", 64'(n_out), 64'd4);

        // Reset with two operations in flight
        pend.push_back(mk(7'b0110011, 3'd0, 1'b0, 64'd1, 64'd1, 64'd0));
        pend.push_back(mk(7'b0110011, 3'd0, 1'b0, 64'd2, 64'd2, 64'd0));
        step(1'b0);
        step(1'b0);
        check("rst_inflight", 64'(sb.size()), 64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result",    result,    0);
        sb.delete();
        pend.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_in_ready", in_ready, 1);
        n_out = 0;
        repeat (6) step(1'b1);
        check("midrst_no_outputs", 64'(n_out), 64'd0);

        // Random traffic
        chk_lat = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (pend.size() < 3) pend.push_back(rand_op());
            drv = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0);
        end
        drv = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
